// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants (round constants, initial hash value), FSM state type and helpers.
package sha256_pkg;

  typedef enum logic [1:0] {StIdle, StRound, StUpdate} state_e;

  localparam logic [255:0] InitH = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] RoundK [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Message-schedule sigmas (lower-case sigma in the standard).
  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round; working vars packed as {a,b,c,d,e,f,g,h}.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [7:0][31:0] st_i,
  input  logic [31:0]      k_i,
  input  logic [31:0]      w_i,
  output logic [7:0][31:0] st_o
);

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] big_sigma0, big_sigma1, ch, maj, t1, t2;

  assign {a, b, c, d, e, f, g, h} = st_i;

  assign big_sigma0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
  assign big_sigma1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
  assign ch         = (e & f) ^ (~e & g);
  assign maj        = (a & b) ^ (a & c) ^ (b & c);
  assign t1         = h + big_sigma1 + ch + k_i + w_i;
  assign t2         = big_sigma0 + maj;

  assign st_o = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_round_sched.sv
// SHA-256 block engine: ROUNDS_PER_CYCLE chained rounds per clock plus chained H update.
// Optional feature: define SHA256_ABORT_EN to add an abort input that cancels a block mid-round.
module sha256_round_sched
  import sha256_pkg::*;
#(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset,
`ifdef SHA256_ABORT_EN
  input  logic         abort,
`endif
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
  output logic         hash_valid,
  output logic [255:0] hashed,
  output logic         busy
);

  localparam int unsigned R = ROUNDS_PER_CYCLE;

  state_e                state_q, state_d;
  logic [5:0]            t_q, t_d;
  logic [7:0][31:0]      h_q, h_d;
  logic [7:0][31:0]      work_q, work_d;
  logic [15:0][31:0]     w_q, w_d;
  logic                  last_q, last_d;
  logic                  hv_q, hv_d;
  logic [7:0][31:0]      h_start;
  logic [7:0][31:0]      chain [R+1];
  logic [R-1:0][31:0]    w_new;

  // w_q[0] always holds W[t]; each round stage j consumes w_q[j].
  assign chain[0] = work_q;
  for (genvar j = 0; j < R; j++) begin : g_round
    logic [5:0] k_idx;
    assign k_idx = t_q + 6'(j);
    sha256_round u_round (
      .st_i (chain[j]),
      .k_i  (RoundK[k_idx]),
      .w_i  (w_q[j]),
      .st_o (chain[j+1])
    );
    assign w_new[j] = small_sigma1(w_q[14+j]) + w_q[9+j] + small_sigma0(w_q[1+j]) + w_q[j];
  end

  assign h_start = blk_first ? InitH : h_q;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    h_d     = h_q;
    work_d  = work_q;
    w_d     = w_q;
    last_d  = last_q;
    hv_d    = hv_q;
    case (state_q)
      StIdle: begin
        if (blk_valid) begin
          for (int i = 0; i < 16; i++) w_d[i] = blk_data[511-32*i -: 32];
          last_d  = blk_last;
          hv_d    = 1'b0;
          h_d     = h_start;
          work_d  = h_start;
          t_d     = '0;
          state_d = StRound;
        end
      end
      StRound: begin
        work_d = chain[R];
        w_d    = {w_new, w_q[15:R]};
        t_d    = t_q + 6'(R);
        if (7'(t_q) + 7'(R) == 7'd64) state_d = StUpdate;
`ifdef SHA256_ABORT_EN
        // Drop the block; H still holds the value chained from the previous block.
        if (abort) begin
          t_d     = '0;
          state_d = StIdle;
        end
`endif
      end
      StUpdate: begin
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + work_q[i];
        hv_d    = last_q;
        t_d     = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      t_q     <= '0;
      h_q     <= '0;
      work_q  <= '0;
      w_q     <= '0;
      last_q  <= 1'b0;
      hv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      h_q     <= h_d;
      work_q  <= work_d;
      w_q     <= w_d;
      last_q  <= last_d;
      hv_q    <= hv_d;
    end
  end

  assign blk_ready  = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign hash_valid = hv_q;
  assign hashed     = h_q;

endmodule

// File: doc/sha256_round_sched.md
SHA256_ROUND_SCHED -- requirements
Module: sha256_round_sched

Interface
REQ-001 SHALL have parameter ROUNDS_PER_CYCLE, default 1, compression rounds per clock; legal values 1 or 2.
REQ-002 SHALL have port clk  input  1  system clock; the only clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port blk_valid  input  1  a 512-bit padded block is offered.
REQ-005 SHALL have port blk_ready  output  1  the block can be accepted this cycle.
REQ-006 SHALL have port blk_data  input  512  padded block; word 0 = blk_data[511:480].
REQ-007 SHALL have port blk_first  input  1  first block of a message; load the IV before compression.
REQ-008 SHALL have port blk_last  input  1  last block of a message; publish the digest after it.
REQ-009 SHALL have port hash_valid  output  1  hashed holds a finished digest.
REQ-010 SHALL have port hashed  output  256  digest {H0..H7}, with H0 in [255:224].
REQ-011 SHALL have port busy  output  1  a block is being compressed.

Function
REQ-012 SHALL use FSM states IDLE, ROUND and UPDATE.
REQ-013 SHALL accept a block on the rising edge where blk_valid&&blk_ready; blk_ready=1 only in IDLE.
REQ-014 On accept, SHALL latch blk_data, blk_last and the 16 message words.
REQ-015 On accept with blk_first=1, SHALL load H with the IV; with blk_first=0, SHALL keep the chained H.
REQ-016 On accept, SHALL set a..h to the H value in use and go to ROUND.
REQ-017 SHALL clear hash_valid on any accepted block.
REQ-018 In ROUND, SHALL perform ROUNDS_PER_CYCLE rounds per cycle using K[t] and W[t].
REQ-019 The round counter t SHALL run 0..63 and SHALL leave ROUND when t+ROUNDS_PER_CYCLE reaches 64.
REQ-020 SHALL generate W with a 16-word shift register: W[t]=sigma1(W[t-2])+W[t-7]+sigma0(W[t-15])+W[t-16] for t>=16.
REQ-021 All additions SHALL be mod 2^32 with carries discarded.
REQ-022 In UPDATE (one cycle), SHALL set Hi <= Hi + {a..h}i and return to IDLE.
REQ-023 If the latched blk_last=1, SHALL set hash_valid=1 on the same edge as REQ-022.
REQ-024 hash_valid SHALL then hold, and hashed SHALL stay stable, until the next accept or reset.
REQ-025 Latency from the accept edge to hash_valid=1 SHALL be 64/ROUNDS_PER_CYCLE+1 cycles (65 for R=1, 33 for R=2).
REQ-026 busy SHALL be 1 in ROUND and UPDATE, and 0 in IDLE.
REQ-027 blk_valid outside IDLE SHALL be ignored; no queueing, and the source must hold the block.
REQ-028 blk_first and blk_last both 1 SHALL be a legal single-block message.
REQ-029 hashed SHALL always show the current H; it is meaningful only while hash_valid=1.

Reset
REQ-030 reset SHALL force IDLE, t=0, H=0, a..h=0, W=0, hash_valid=0, busy=0, blk_ready=1 on the next edge.
REQ-031 reset SHALL take priority over every event, including an accept in the same cycle.
REQ-032 reset mid-ROUND or mid-UPDATE SHALL discard all work; no partial digest ever asserts hash_valid.

Configuration
REQ-033 With macro SHA256_ABORT_EN defined, SHALL add port abort  input  1.
REQ-034 abort=1 in ROUND SHALL return the FSM to IDLE next edge, with H unchanged and hash_valid=0.
REQ-035 abort in IDLE or UPDATE SHALL have no effect.
REQ-036 Without SHA256_ABORT_EN, the abort port and its logic SHALL be absent.

Structure
REQ-037 Package sha256_pkg SHALL hold the K[0:63] table, the IV constants and the FSM state enum typedef.
REQ-038 A sub-module sha256_round SHALL implement one combinational round: inputs a..h, K, W; outputs a'..h'.
REQ-039 sha256_round SHALL be instantiated ROUNDS_PER_CYCLE times, chained.
REQ-040 sha256_round SHALL include the Ch, Maj, Sigma0 and Sigma1 functions.

Verification
REQ-041 Padded "abc", first=last=1 -> hashed=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad; hash_valid rises 65 cycles after accept (R=1).
REQ-042 Padded empty message -> hashed=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
REQ-043 Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> hashed=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, with no hash_valid after block 1.
REQ-044 reset at round 30 of "abc", then resend -> hash_valid stays 0 until the REQ-041 digest appears.
REQ-045 blk_valid held during ROUND -> blk_ready=0 and no accept until IDLE; rerun REQ-041 with R=2 -> latency 33.
REQ-046 With SHA256_ABORT_EN: abort at round 10 of block 2 -> IDLE, H equals the post-block-1 value, hash_valid=0.
